// File: rtl/berger_b1_faulty_memory_pkg.sv
// Shared constants and the stored-word layout for the Berger B1 memory.
// A stored word is {check, data}, with check = number of ones in data.
package berger_b1_faulty_memory_pkg;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int CHECK_W = $clog2(DATA_W + 1);
  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int WORD_W  = DATA_W + CHECK_W;

  // Packed so that check lands in the upper bits: [11:8] check, [7:0] data.
  typedef struct packed {
    logic [CHECK_W-1:0] check;
    logic [DATA_W-1:0]  data;
  } word_t;

endpackage

// File: rtl/berger_ones_counter.sv
// Population count of a WIDTH-bit vector.
// Ports:
//   bits  - input vector
//   count - number of bits set in 'bits'
module berger_ones_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] bits,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CNT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/berger_b1_faulty_memory.sv
// 16-word register-file memory storing each byte with its Berger B1 check
// (the ones count of the data). The read path can be corrupted by a
// unidirectional fault mask; the check is recomputed over the faulted data
// and compared with the faulted stored check.
// Ports:
//   clk                       - clock, writes on rising edge
//   rst                       - asynchronous active-low reset, clears memory
//   input_data                - write data
//   input_addr                - shared read/write address
//   wr_en                     - write strobe
//   unidirectional_fault_mask - bit positions of the read word to corrupt
//   fault_enable              - apply the mask when high
//   fault_zero_to_one         - 0: masked bits forced to 0, 1: forced to 1
//   output_data               - data field of the faulted read word
//   one_to_zero_error         - recomputed check differs from stored check
module berger_b1_faulty_memory
  import berger_b1_faulty_memory_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] input_data,
  input  logic [ADDR_W-1:0] input_addr,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] unidirectional_fault_mask,
  input  logic              fault_enable,
  input  logic              fault_zero_to_one,
  output logic [DATA_W-1:0] output_data,
  output logic              one_to_zero_error
);

  word_t              mem_reg [DEPTH];
  word_t              write_word;
  word_t              raw_word;
  word_t              faulted_word;
  logic [CHECK_W-1:0] write_check;
  logic [CHECK_W-1:0] read_check;

  // Encoder on the write side.
  berger_ones_counter #(
    .WIDTH (DATA_W),
    .CNT_W (CHECK_W)
  ) u_write_counter (
    .bits  (input_data),
    .count (write_check)
  );

  assign write_word = '{check: write_check, data: input_data};

  // Asynchronous clear is required here, so the array is held in flops
  // rather than block RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (wr_en) begin
      mem_reg[input_addr] <= write_word;
    end
  end

  // Zero-latency read with fault injection applied to the whole word,
  // check field included.
  always_comb begin
    raw_word     = mem_reg[input_addr];
    faulted_word = raw_word;
    if (fault_enable) begin
      if (fault_zero_to_one) begin
        faulted_word = raw_word | unidirectional_fault_mask;
      end else begin
        faulted_word = raw_word & ~unidirectional_fault_mask;
      end
    end
  end

  // Checker on the read side, over the faulted data.
  berger_ones_counter #(
    .WIDTH (DATA_W),
    .CNT_W (CHECK_W)
  ) u_read_counter (
    .bits  (faulted_word.data),
    .count (read_check)
  );

  // No correction: data is passed through as faulted. A 1->0 fault that
  // drops data ones and stored check to the same value is undetectable.
  assign output_data       = faulted_word.data;
  assign one_to_zero_error = (read_check != faulted_word.check);

endmodule

// File: tb/tb_berger_b1_faulty_memory.sv
// Self-checking bench for berger_b1_faulty_memory: directed cases from the
// code's definition plus randomized traffic against a behavioural model.
module tb_berger_b1_faulty_memory;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  input_data = '0;
  logic [3:0]  input_addr = '0;
  logic        wr_en = 1'b0;
  logic [11:0] unidirectional_fault_mask = '0;
  logic        fault_enable = 1'b0;
  logic        fault_zero_to_one = 1'b0;
  logic [7:0]  output_data;
  logic        one_to_zero_error;

  int checks   = 0;
  int failures = 0;

  logic [11:0] model_mem [16];

  berger_b1_faulty_memory dut (
    .clk                       (clk),
    .rst                       (rst),
    .input_data                (input_data),
    .input_addr                (input_addr),
    .wr_en                     (wr_en),
    .unidirectional_fault_mask (unidirectional_fault_mask),
    .fault_enable              (fault_enable),
    .fault_zero_to_one         (fault_zero_to_one),
    .output_data               (output_data),
    .one_to_zero_error         (one_to_zero_error)
  );

  always #5 clk = ~clk;

  // Model: stored word is {ones(data), data}; faults are plain AND/OR.
  function automatic logic [11:0] model_encode(input logic [7:0] d);
    logic [3:0] c;
    c = 4'($countones(d));
    return {c, d};
  endfunction

  function automatic logic [11:0] model_fault(input logic [11:0] w, input logic en,
                                              input logic z2o, input logic [11:0] m);
    if (!en) return w;
    if (z2o) return w | m;
    return w & ~m;
  endfunction

  function automatic logic model_err(input logic [11:0] f);
    logic [7:0] d;
    d = f[7:0];
    return ($countones(d) != int'(f[11:8]));
  endfunction

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    input_addr = a;
    input_data = d;
    wr_en      = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    model_mem[a] = model_encode(d);
  endtask

  task automatic set_read(input logic [3:0] a, input logic en, input logic z2o,
                          input logic [11:0] m);
    input_addr                = a;
    fault_enable              = en;
    fault_zero_to_one         = z2o;
    unidirectional_fault_mask = m;
    #1;
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    wr_en = 1'b1;
    input_data = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    wr_en = 1'b0;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    for (int a = 0; a < 16; a += 5) begin
      set_read(4'(a), 1'b0, 1'b0, 12'h000);
      checks++;
      if (output_data !== 8'h00 || one_to_zero_error !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold addr=%0d got data=%h err=%b want data=00 err=0",
                 a, output_data, one_to_zero_error);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    set_read(4'd0, 1'b0, 1'b0, 12'h000);
    checks++;
    if (output_data !== 8'h00 || one_to_zero_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_write_ignored got data=%h err=%b want data=00 err=0",
               output_data, one_to_zero_error);
    end
    $display("test_reset done");
  endtask

  task automatic test_clean_reads();
    logic [7:0] vals [8];
    vals = '{8'hA5, 8'h3D, 8'hFB, 8'h00, 8'h5A, 8'hC3, 8'h1E, 8'hB4};
    for (int i = 0; i < 8; i++) do_write(4'(i), vals[i]);
    for (int i = 0; i < 8; i++) begin
      set_read(4'(i), 1'b0, 1'b0, 12'hFFF);
      checks++;
      if (output_data !== vals[i] || one_to_zero_error !== 1'b0) begin
        failures++;
        $display("FAIL clean_read addr=%0d got data=%h err=%b want data=%h err=0",
                 i, output_data, one_to_zero_error, vals[i]);
      end
      $display("clean_read addr=%0d data=%h err=%b", i, output_data, one_to_zero_error);
    end
  endtask

  task automatic test_directed_faults();
    // addr, z2o, mask, expected data, expected error
    logic [3:0]  c_addr [20];
    logic        c_z2o  [20];
    logic [11:0] c_mask [20];
    logic [7:0]  c_data [20];
    logic        c_err  [20];
    c_addr = '{0,0,0,0, 0,0,0,0, 0, 0,0,0, 1,1, 0, 3,3, 0, 2, 2};
    c_z2o  = '{0,0,0,0, 0,0,0,0, 0, 0,0,0, 0,0, 0, 0,0, 1, 0, 1};
    c_mask = '{12'h001,12'h004,12'h020,12'h080,
               12'h002,12'h008,12'h010,12'h040,
               12'h400,
               12'h100,12'h200,12'h800,
               12'h00D,12'hF00,
               12'h4A5,
               12'hFFF,12'h5A3,
               12'h002,
               12'h700,
               12'h004};
    c_data = '{8'hA4,8'hA1,8'h85,8'h25,
               8'hA5,8'hA5,8'hA5,8'hA5,
               8'hA5,
               8'hA5,8'hA5,8'hA5,
               8'h30,8'h3D,
               8'h00,
               8'h00,8'h00,
               8'hA7,
               8'hFB,
               8'hFF};
    c_err  = '{1,1,1,1, 0,0,0,0, 1, 0,0,0, 1,1, 0, 0,0, 1, 1, 1};
    for (int i = 0; i < 20; i++) begin
      set_read(c_addr[i], 1'b1, c_z2o[i], c_mask[i]);
      checks++;
      if (output_data !== c_data[i] || one_to_zero_error !== c_err[i]) begin
        failures++;
        $display("FAIL directed_fault idx=%0d addr=%0d mask=%h z2o=%b got data=%h err=%b want data=%h err=%b",
                 i, c_addr[i], c_mask[i], c_z2o[i], output_data, one_to_zero_error,
                 c_data[i], c_err[i]);
      end
      $display("directed_fault addr=%0d mask=%h z2o=%b data=%h err=%b",
               c_addr[i], c_mask[i], c_z2o[i], output_data, one_to_zero_error);
    end
    set_read(4'd0, 1'b0, 1'b0, 12'h000);
  endtask

  task automatic test_same_cycle();
    @(posedge clk);
    #1;
    input_addr   = 4'd9;
    input_data   = 8'h0F;
    wr_en        = 1'b1;
    fault_enable = 1'b0;
    #2;
    checks++;
    if (output_data !== model_mem[9][7:0]) begin
      failures++;
      $display("FAIL same_cycle_old got=%h want=%h", output_data, model_mem[9][7:0]);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    model_mem[9] = model_encode(8'h0F);
    checks++;
    if (output_data !== 8'h0F || one_to_zero_error !== 1'b0) begin
      failures++;
      $display("FAIL same_cycle_new got data=%h err=%b want data=0f err=0",
               output_data, one_to_zero_error);
    end
    $display("same_cycle addr=9 data=%h", output_data);
  endtask

  task automatic test_random();
    logic [3:0]  a;
    logic [7:0]  d;
    logic [11:0] m;
    logic        en;
    logic        z2o;
    logic [11:0] f;
    for (int n = 0; n < 150; n++) begin
      a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) begin
        d = 8'($urandom);
        do_write(a, d);
      end else begin
        m   = 12'($urandom);
        en  = 1'($urandom);
        z2o = 1'($urandom);
        set_read(a, en, z2o, m);
        f = model_fault(model_mem[a], en, z2o, m);
        checks++;
        if (output_data !== f[7:0] || one_to_zero_error !== model_err(f)) begin
          failures++;
          $display("FAIL random_read addr=%0d en=%b z2o=%b mask=%h got data=%h err=%b want data=%h err=%b",
                   a, en, z2o, m, output_data, one_to_zero_error, f[7:0], model_err(f));
        end
      end
    end
    set_read(4'd0, 1'b0, 1'b0, 12'h000);
    $display("test_random done");
  endtask

  task automatic test_reset_mid_run();
    do_write(4'd4, 8'h77);
    set_read(4'd4, 1'b0, 1'b0, 12'h000);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    checks++;
    if (output_data !== 8'h00 || one_to_zero_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_run got data=%h err=%b want data=00 err=0",
               output_data, one_to_zero_error);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_read(4'(i), 1'b0, 1'b0, 12'h000);
      checks++;
      if (output_data !== 8'h00 || one_to_zero_error !== 1'b0) begin
        failures++;
        $display("FAIL reset_cleared addr=%0d got data=%h err=%b want data=00 err=0",
                 i, output_data, one_to_zero_error);
      end
    end
    $display("reset_mid_run done");
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    test_reset();
    test_clean_reads();
    test_directed_faults();
    test_same_cycle();
    test_random();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
